// File: rtl/access_pkg.sv
// Shared types, widths and key helper for the access controller.
package access_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'b00,
      ST_OK      = 2'b01,
      ST_LOCKED  = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

   localparam int KEY_MAX_W = 256;

   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int fail_w(input int max_fails);
      return width_of(max_fails + 1);
   endfunction

   function automatic int idx_w(input int num_digits);
      return width_of(num_digits);
   endfunction

   function automatic int timer_w(input int lock_c, input int idle_c);
      return width_of((lock_c > idle_c) ? lock_c : idle_c);
   endfunction

   localparam int DEF_FAIL_W  = fail_w(3);
   localparam int DEF_IDX_W   = idx_w(4);
   localparam int DEF_TIMER_W = timer_w(50_000_000, 0);

   // First digit lives in the most significant slice of the key.
   function automatic logic [31:0] key_digit(
      input logic [KEY_MAX_W-1:0] key,
      input int                   dw,
      input int                   nd,
      input int                   idx
   );
      logic [31:0] mask;
      mask = (32'h1 << dw) - 32'h1;
      return 32'(key >> ((nd - 1 - idx) * dw)) & mask;
   endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter, shared by lockout and idle timeout.
module access_timer #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/access_lock.sv
// Password entry, access gating of player load strobes and timed lockout.
module access_lock
   import access_pkg::*;
#(
   parameter int DIGIT_W     = 4,
   parameter int NUM_DIGITS  = 4,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] KEY = 16'h3153,
   parameter int NUM_CH      = 2,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 50_000_000,
   parameter int IDLE_CYCLES = 0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DIGIT_W-1:0]            pword,
   input  logic                          pword_enter,
   input  logic [NUM_CH-1:0]             load_in,
   output logic [NUM_CH-1:0]             load_out,
   output logic                          pass_red,
   output logic                          pass_green,
   output logic                          locked,
   output logic [fail_w(MAX_FAILS)-1:0]  fail_count,
   output logic [1:0]                    currentstate
);

   localparam int IDX_W  = idx_w(NUM_DIGITS);
   localparam int TW     = timer_w(LOCK_CYCLES, IDLE_CYCLES);
   localparam int FAIL_W = fail_w(MAX_FAILS);
   localparam bit IDLE_EN = (IDLE_CYCLES > 0);

   localparam logic [KEY_MAX_W-1:0] KEY_EXT = KEY_MAX_W'(KEY);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [TW-1:0] LOCK_RL = TW'(LOCK_CYCLES - 1);
   localparam logic [TW-1:0] IDLE_RL =
      TW'(IDLE_EN ? IDLE_CYCLES - 1 : 0);

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic                mis, mis_n;
   logic [FAIL_W-1:0]   fail_n;
   logic [NUM_CH-1:0]   load_n;
   logic                t_load, t_en, t_zero;
   logic [TW-1:0]       t_val;
   logic [31:0]         key_dig;
   logic                cur_mis;

   assign key_dig = key_digit(KEY_EXT, DIGIT_W, NUM_DIGITS, int'(idx));
   assign cur_mis = (32'(pword) != key_dig);

   access_timer #(.W(TW)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (t_load),
      .load_val (t_val),
      .en       (t_en),
      .zero     (t_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= ST_ENTRY;
         idx        <= '0;
         mis        <= 1'b0;
         fail_count <= '0;
         load_out   <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         mis        <= mis_n;
         fail_count <= fail_n;
         load_out   <= load_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      mis_n   = mis;
      fail_n  = fail_count;
      t_load  = 1'b0;
      t_val   = '0;
      t_en    = 1'b0;
      unique case (state)
         ST_ENTRY: begin
            if (pword_enter) begin
               if (idx == LAST_IDX) begin
                  idx_n = '0;
                  mis_n = 1'b0;
                  if (!(mis || cur_mis)) begin
                     state_n = ST_OK;
                     fail_n  = '0;
                     t_load  = 1'b1;
                     t_val   = IDLE_RL;
                  end else if (int'(fail_count) + 1 < MAX_FAILS) begin
                     fail_n = fail_count + FAIL_W'(1);
                  end else begin
                     state_n = ST_LOCKED;
                     fail_n  = FAIL_W'(MAX_FAILS);
                     t_load  = 1'b1;
                     t_val   = LOCK_RL;
                  end
               end else begin
                  idx_n = idx + IDX_W'(1);
                  mis_n = mis || cur_mis;
               end
            end
         end
         ST_OK: begin
            // Enter and timeout together still give one logout.
            if (pword_enter) begin
               state_n = ST_ENTRY;
            end else if (IDLE_EN) begin
               if (|load_in) begin
                  t_load = 1'b1;
                  t_val  = IDLE_RL;
               end else if (t_zero) begin
                  state_n = ST_ENTRY;
               end else begin
                  t_en = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (t_zero) begin
               state_n = ST_ENTRY;
               fail_n  = '0;
            end else begin
               t_en = 1'b1;
            end
         end
         default: begin
            state_n = ST_ENTRY;
            idx_n   = '0;
            mis_n   = 1'b0;
            fail_n  = '0;
         end
      endcase
   end

   always_comb begin
      pass_red     = (state != ST_OK);
      pass_green   = (state == ST_OK);
      locked       = (state == ST_LOCKED);
      currentstate = state;
      load_n       = '0;
      if (state == ST_OK && state_n == ST_OK) begin
         load_n = load_in;
      end
   end

endmodule

// File: doc/access_lock.md
Name: access_lock

Overview:
Parametrised login/access controller for the game I/O path. Compares a sequence of NUM_DIGITS user-entered digits against a compile-time key. On a match it opens NUM_CH player load-register gates. On repeated failures it enters a timed lockout. It sits between the switch/button conditioning logic and the per-player loadreg modules.

Parameters:
DIGIT_W, 4, width of one password digit
NUM_DIGITS, 4, digits per password
KEY, 16'h3153, packed key of NUM_DIGITS*DIGIT_W bits; first digit in the MS slice
NUM_CH, 2, number of gated player load channels
MAX_FAILS, 3, consecutive failed attempts before lockout (>=1)
LOCK_CYCLES, 50_000_000, lockout duration in CLK cycles
IDLE_CYCLES, 0, auto-logout after this many idle cycles in OK; 0 disables

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-low reset
pword  in  DIGIT_W  current digit from switches
pword_enter  in  1  one-cycle digit-accept pulse (shaped upstream)
load_in  in  NUM_CH  per-player load request buttons
load_out  out  NUM_CH  gated load strobes to loadreg modules
pass_red  out  1  access denied indicator
pass_green  out  1  access granted indicator
locked  out  1  lockout indicator
fail_count  out  clog2(MAX_FAILS+1)  consecutive failed attempts
currentstate  out  2  state, debug/sim only

Behaviour:
- Everything is registered on posedge CLK. RST is decided as synchronous, active-low on CLK.
- Reset values: state ENTRY, digit index 0, mismatch flag 0, pass_red=1, pass_green=0, locked=0, load_out=0, fail_count=0, timer 0.
- Reset mid-operation (including during lockout or OK) returns to the reset values on the next edge.
- States:
  - ENTRY=2'b00: collects digits.
  - OK=2'b01: access granted.
  - LOCKED=2'b10: timed lockout.
  - 2'b11 is illegal and goes to ENTRY with reset outputs.
- ENTRY, per pword_enter pulse:
  - Compare pword with KEY slice [digit index]; on mismatch set the mismatch flag.
  - Increment the digit index.
  - pword_enter held high for k cycles counts as k digits.
- ENTRY, on the pulse for the last digit (index NUM_DIGITS-1):
  - Evaluate (mismatch flag OR current mismatch).
  - Clear the index and the flag.
  - Match: go to OK, fail_count <= 0.
  - Mismatch with fail_count+1 < MAX_FAILS: stay in ENTRY, fail_count increments.
  - Mismatch with fail_count+1 == MAX_FAILS: go to LOCKED, load timer with LOCK_CYCLES-1, fail_count <= MAX_FAILS.
- Indicators update on the same edge as the state change. In ENTRY and LOCKED: pass_red=1, pass_green=0, load_out=0. In OK: pass_red=0, pass_green=1.
- OK:
  - load_out <= load_in each cycle (one-cycle latency).
  - A pword_enter pulse logs out: go to ENTRY, load_out forced 0 on that edge, even if load_in is active the same cycle.
  - If IDLE_CYCLES>0: the timer reloads with IDLE_CYCLES-1 on entry to OK and on any cycle with pword_enter or any load_in bit high. Otherwise it decrements. At 0 it logs out exactly like pword_enter.
  - Logout from enter and timeout in the same cycle is a single logout.
- LOCKED:
  - locked=1; pword_enter is ignored.
  - The timer decrements each cycle. When it reaches 0: go to ENTRY, fail_count <= 0, locked <= 0.
  - Lockout lasts exactly LOCK_CYCLES cycles.
- The digit index wraps only via last-digit evaluation and never exceeds NUM_DIGITS-1.

Decomposition:
- Package access_pkg holds:
  - the state encoding constants;
  - a helper function for the key-slice select;
  - the clog2-based width constants for fail_count, the digit index and the timer (timer width sized for max(LOCK_CYCLES, IDLE_CYCLES)).
- Sub-module access_timer: loadable down-counter with load, enable and zero outputs. LOCKED and OK are mutually exclusive, so one instance is shared between lockout and idle timeout.

Test Plan:
Sim parameters throughout: KEY=16'h3153, MAX_FAILS=3, LOCK_CYCLES=8, IDLE_CYCLES=16.
- Enter 3,1,5,3 -> pass_green=1 and pass_red=0 on the edge sampling the 4th pulse; fail_count=0.
- In OK, pulse load_in=2'b10 -> load_out=2'b10 one cycle later. Then pword_enter together with load_in=2'b11 -> ENTRY, load_out=0, pass_red=1.
- Enter 3,1,5,4, then 7,1,5,3 -> both attempts rejected and fail_count=2; last-digit-only and first-digit-only errors are both caught.
- Three wrong attempts -> locked=1 for exactly 8 cycles, with pword_enter pulses ignored. Then ENTRY with fail_count=0, and 3,1,5,3 succeeds.
- In OK with no activity for 16 cycles -> auto-logout to ENTRY. A load_in pulse at cycle 10 restarts the count.
- Assert RST=0 mid-lockout and mid-entry (after 2 digits) -> all outputs at reset values next edge. A fresh 3,1,5,3 then succeeds.
